// File: rtl/cpu_controller_if.sv
// Datapath control and memory command bundle between the sequencing
// controller (master) and the datapath/memory (slave).
interface cpu_controller_if;
  logic        [15:0] mdata;
  logic        [2:0]  readnum;
  logic        [2:0]  writenum;
  logic               write;
  logic        [3:0]  vsel;
  logic               loada;
  logic               loadb;
  logic               loadc;
  logic               loads;
  logic        [1:0]  shift;
  logic               asel;
  logic               bsel;
  logic        [1:0]  ALUop;
  logic signed [15:0] sximm5;
  logic signed [15:0] sximm8;
  logic               load_pc;
  logic               reset_pc;
  logic               load_addr;
  logic               addr_sel;
  logic        [1:0]  mem_cmd;
  logic               halted;

  modport master (
    input  mdata,
    output readnum, writenum, write, vsel, loada, loadb, loadc, loads,
           shift, asel, bsel, ALUop, sximm5, sximm8, load_pc, reset_pc,
           load_addr, addr_sel, mem_cmd, halted
  );

  modport slave (
    output mdata,
    input  readnum, writenum, write, vsel, loada, loadb, loadc, loads,
           shift, asel, bsel, ALUop, sximm5, sximm8, load_pc, reset_pc,
           load_addr, addr_sel, mem_cmd, halted
  );
endinterface

// File: rtl/cpu_controller.sv
// Instruction fetch/decode/sequencing FSM for the simple RISC machine.
// Holds the instruction register and steps the datapath through a fixed
// Moore state sequence for each instruction class.
module cpu_controller (
  input  logic               clk,
  input  logic               reset_n,
  cpu_controller_if.master   bus
);

  typedef enum logic [4:0] {
    S_RST, S_IF1, S_IF2, S_UPC, S_DEC, S_WIMM, S_GETA, S_GETB, S_ALU,
    S_WB, S_ADDR, S_LADR, S_LMEM, S_LWB, S_SGETB, S_SMOV, S_SMEM, S_HALT
  } state_t;

  typedef enum logic [1:0] {NSEL_NONE, NSEL_RN, NSEL_RD, NSEL_RM} nsel_t;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  state_t      state, next_state;
  logic [15:0] ir;
  logic        load_ir;
  nsel_t       nsel;

  // Instruction fields
  logic [2:0] opcode, rn, rd, rm;
  logic [1:0] op, sh;
  logic [4:0] opk;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];
  assign opk    = {opcode, op};

  localparam logic [4:0] K_MOVI = 5'b110_10;
  localparam logic [4:0] K_MOVR = 5'b110_00;
  localparam logic [4:0] K_MVN  = 5'b101_11;
  localparam logic [4:0] K_ADD  = 5'b101_00;
  localparam logic [4:0] K_CMP  = 5'b101_01;
  localparam logic [4:0] K_AND  = 5'b101_10;
  localparam logic [4:0] K_LDR  = 5'b011_00;
  localparam logic [4:0] K_STR  = 5'b100_00;

  function automatic logic signed [15:0] sext5(input logic [4:0] f);
    logic signed [4:0]  s;
    logic signed [15:0] r;
    s = f;
    r = s;
    return r;
  endfunction

  function automatic logic signed [15:0] sext8(input logic [7:0] f);
    logic signed [7:0]  s;
    logic signed [15:0] r;
    s = f;
    r = s;
    return r;
  endfunction

  // State register; reset forces RST immediately, even mid-instruction
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_RST;
    else          state <= next_state;
  end

  // Instruction register, captured at the end of the second fetch cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     ir <= '0;
    else if (load_ir) ir <= bus.mdata;
  end

  // Next-state sequencing
  always_comb begin
    next_state = S_IF1;
    unique case (state)
      S_RST:   next_state = S_IF1;
      S_IF1:   next_state = S_IF2;
      S_IF2:   next_state = S_UPC;
      S_UPC:   next_state = S_DEC;
      S_DEC: begin
        if (opcode == 3'b111)                       next_state = S_HALT;
        else if (opk == K_MOVI)                     next_state = S_WIMM;
        else if (opk == K_MOVR || opk == K_MVN)     next_state = S_GETB;
        else if (opk == K_ADD || opk == K_CMP || opk == K_AND ||
                 opk == K_LDR || opk == K_STR)      next_state = S_GETA;
        else                                        next_state = S_IF1;
      end
      S_WIMM:  next_state = S_IF1;
      S_GETA:  next_state = (opk == K_LDR || opk == K_STR) ? S_ADDR : S_GETB;
      S_GETB:  next_state = S_ALU;
      S_ALU:   next_state = (opk == K_CMP) ? S_IF1 : S_WB;
      S_WB:    next_state = S_IF1;
      S_ADDR:  next_state = S_LADR;
      S_LADR:  next_state = (opk == K_LDR) ? S_LMEM : S_SGETB;
      S_LMEM:  next_state = S_LWB;
      S_LWB:   next_state = S_IF1;
      S_SGETB: next_state = S_SMOV;
      S_SMOV:  next_state = S_SMEM;
      S_SMEM:  next_state = S_IF1;
      S_HALT:  next_state = S_HALT;
      default: next_state = S_RST;
    endcase
  end

  // Moore outputs per state; IR-derived fields pass through unless overridden
  always_comb begin
    load_ir       = 1'b0;
    nsel          = NSEL_NONE;
    bus.write     = 1'b0;
    bus.vsel      = 4'b0001;
    bus.loada     = 1'b0;
    bus.loadb     = 1'b0;
    bus.loadc     = 1'b0;
    bus.loads     = 1'b0;
    bus.shift     = sh;
    bus.asel      = 1'b0;
    bus.bsel      = 1'b0;
    bus.ALUop     = op;
    bus.load_pc   = 1'b0;
    bus.reset_pc  = 1'b0;
    bus.load_addr = 1'b0;
    bus.addr_sel  = 1'b0;
    bus.mem_cmd   = MEM_NONE;
    bus.halted    = 1'b0;
    unique case (state)
      S_RST:   begin bus.reset_pc = 1'b1; bus.load_pc = 1'b1; end
      S_IF1:   begin bus.addr_sel = 1'b1; bus.mem_cmd = MEM_READ; end
      S_IF2:   begin bus.addr_sel = 1'b1; bus.mem_cmd = MEM_READ; load_ir = 1'b1; end
      S_UPC:   bus.load_pc = 1'b1;
      S_DEC:   ;
      S_WIMM:  begin nsel = NSEL_RN; bus.vsel = 4'b0100; bus.write = 1'b1; end
      S_GETA:  begin nsel = NSEL_RN; bus.loada = 1'b1; end
      S_GETB:  begin nsel = NSEL_RM; bus.loadb = 1'b1; end
      S_ALU: begin
        bus.loadc = 1'b1;
        bus.asel  = (opk == K_MOVR || opk == K_MVN);
        bus.loads = (opk == K_CMP);
      end
      S_WB:    begin nsel = NSEL_RD; bus.write = 1'b1; end
      S_ADDR:  begin bus.bsel = 1'b1; bus.ALUop = 2'b00; bus.loadc = 1'b1; end
      S_LADR:  bus.load_addr = 1'b1;
      S_LMEM:  bus.mem_cmd = MEM_READ;
      S_LWB: begin
        bus.mem_cmd = MEM_READ;
        nsel        = NSEL_RD;
        bus.vsel    = 4'b1000;
        bus.write   = 1'b1;
      end
      S_SGETB: begin nsel = NSEL_RD; bus.loadb = 1'b1; end
      S_SMOV: begin
        bus.asel  = 1'b1;
        bus.ALUop = 2'b00;
        bus.shift = 2'b00;
        bus.loadc = 1'b1;
      end
      S_SMEM:  bus.mem_cmd = MEM_WRITE;
      S_HALT:  bus.halted = 1'b1;
      default: ;
    endcase
  end

  // Register index mux shared by read and write ports
  always_comb begin
    unique case (nsel)
      NSEL_RN: bus.readnum = rn;
      NSEL_RD: bus.readnum = rd;
      NSEL_RM: bus.readnum = rm;
      default: bus.readnum = 3'b000;
    endcase
  end

  assign bus.writenum = bus.readnum;
  assign bus.sximm5   = sext5(ir[4:0]);
  assign bus.sximm8   = sext8(ir[7:0]);

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller: each stimulus slot pushes the
// hand-computed per-cycle control vector; a negedge monitor pops and compares.
module tb_cpu_controller;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  cpu_controller_if bus ();

  cpu_controller dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic [3:0]  vsel;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic [1:0]  shift;
    logic        asel;
    logic        bsel;
    logic [1:0]  ALUop;
    logic [15:0] sximm5;
    logic [15:0] sximm8;
    logic        load_pc;
    logic        reset_pc;
    logic        load_addr;
    logic        addr_sel;
    logic [1:0]  mem_cmd;
    logic        halted;
  } ctl_t;

  ctl_t  exp_q[$];
  logic  fv_q[$];
  string name_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  ctl_t  b;
  ctl_t  rst_v;

  function automatic ctl_t base_of(input logic [15:0] s5, input logic [15:0] s8,
                                   input logic [1:0] sh, input logic [1:0] aop);
    ctl_t v;
    v = '0;
    v.vsel = 4'b0001;
    v.shift = sh;
    v.ALUop = aop;
    v.sximm5 = s5;
    v.sximm8 = s8;
    return v;
  endfunction

  // One clock slot: expected vector for this cycle, sampled at the negedge
  task automatic slot(input ctl_t v, input logic fv, input string nm);
    exp_q.push_back(v);
    fv_q.push_back(fv);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  // IF1/IF2 (IR fields still from the previous instruction), UPC, DEC
  task automatic fetch(input logic [15:0] w, input string nm);
    ctl_t v;
    bus.mdata = w;
    v = b; v.addr_sel = 1'b1; v.mem_cmd = 2'b01;
    slot(v, 1'b0, {nm, ".IF1"});
    slot(v, 1'b0, {nm, ".IF2"});
    v = b; v.load_pc = 1'b1;
    slot(v, 1'b1, {nm, ".UPC"});
    v = b;
    slot(v, 1'b1, {nm, ".DEC"});
  endtask

  task automatic mov_imm_m1();
    ctl_t v;
    b = base_of(16'hFFFF, 16'hFFFF, 2'b11, 2'b10);
    fetch(16'hD0FF, "MOVI");
    v = b; v.vsel = 4'b0100; v.write = 1'b1;
    slot(v, 1'b1, "MOVI.WIMM");
  endtask

  // Monitor: compare DUT outputs against the head of the scoreboard
  ctl_t  act, e, m;
  logic  fv;
  string nm;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      fv = fv_q.pop_front();
      nm = name_q.pop_front();
      act = '{bus.readnum, bus.writenum, bus.write, bus.vsel, bus.loada,
              bus.loadb, bus.loadc, bus.loads, bus.shift, bus.asel, bus.bsel,
              bus.ALUop, bus.sximm5, bus.sximm8, bus.load_pc, bus.reset_pc,
              bus.load_addr, bus.addr_sel, bus.mem_cmd, bus.halted};
      m = '1;
      if (!fv) begin
        m.shift = '0; m.ALUop = '0; m.sximm5 = '0; m.sximm8 = '0;
      end
      vectors++;
      if ((act & m) !== (e & m)) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h (mask %h)", nm, act, e, m);
      end
    end
  end

  initial begin
    ctl_t v;
    bus.mdata = 16'h0000;
    rst_v = base_of(16'h0000, 16'h0000, 2'b00, 2'b00);
    rst_v.reset_pc = 1'b1;
    rst_v.load_pc = 1'b1;
    @(posedge clk);
    #1;

    // Reset held three cycles, then one RST cycle after release
    repeat (3) slot(rst_v, 1'b1, "RESET");
    reset_n = 1'b1;
    slot(rst_v, 1'b1, "RST.release");

    // MOV R0,#-1
    mov_imm_m1();

    // ADD R2,R1,R0,LSL#1
    b = base_of(16'h0008, 16'h0048, 2'b01, 2'b00);
    fetch(16'hA148, "ADD");
    v = b; v.readnum = 3'd1; v.writenum = 3'd1; v.loada = 1'b1; slot(v, 1'b1, "ADD.GETA");
    v = b; v.loadb = 1'b1; slot(v, 1'b1, "ADD.GETB");
    v = b; v.loadc = 1'b1; slot(v, 1'b1, "ADD.ALU");
    v = b; v.readnum = 3'd2; v.writenum = 3'd2; v.write = 1'b1; slot(v, 1'b1, "ADD.WB");

    // CMP R1,R0
    b = base_of(16'h0000, 16'h0000, 2'b00, 2'b01);
    fetch(16'hA900, "CMP");
    v = b; v.readnum = 3'd1; v.writenum = 3'd1; v.loada = 1'b1; slot(v, 1'b1, "CMP.GETA");
    v = b; v.loadb = 1'b1; slot(v, 1'b1, "CMP.GETB");
    v = b; v.loadc = 1'b1; v.loads = 1'b1; slot(v, 1'b1, "CMP.ALU");

    // MVN R1,R2 with sh=10 so sximm5 is negative (0xFFF2)
    b = base_of(16'hFFF2, 16'h0032, 2'b10, 2'b11);
    fetch(16'hB832, "MVN");
    v = b; v.readnum = 3'd2; v.writenum = 3'd2; v.loadb = 1'b1; slot(v, 1'b1, "MVN.GETB");
    v = b; v.loadc = 1'b1; v.asel = 1'b1; slot(v, 1'b1, "MVN.ALU");
    v = b; v.readnum = 3'd1; v.writenum = 3'd1; v.write = 1'b1; slot(v, 1'b1, "MVN.WB");

    // LDR R3,[R0,#1]
    b = base_of(16'h0001, 16'h0061, 2'b00, 2'b00);
    fetch(16'h6061, "LDR");
    v = b; v.loada = 1'b1; slot(v, 1'b1, "LDR.GETA");
    v = b; v.bsel = 1'b1; v.loadc = 1'b1; slot(v, 1'b1, "LDR.ADDR");
    v = b; v.load_addr = 1'b1; slot(v, 1'b1, "LDR.LADR");
    bus.mdata = 16'h1234;
    v = b; v.mem_cmd = 2'b01; slot(v, 1'b1, "LDR.LMEM");
    v = b; v.mem_cmd = 2'b01; v.readnum = 3'd3; v.writenum = 3'd3;
    v.vsel = 4'b1000; v.write = 1'b1; slot(v, 1'b1, "LDR.LWB");

    // STR R3,[R0,#2]
    b = base_of(16'h0002, 16'h0062, 2'b00, 2'b00);
    fetch(16'h8062, "STR");
    v = b; v.loada = 1'b1; slot(v, 1'b1, "STR.GETA");
    v = b; v.bsel = 1'b1; v.loadc = 1'b1; slot(v, 1'b1, "STR.ADDR");
    v = b; v.load_addr = 1'b1; slot(v, 1'b1, "STR.LADR");
    v = b; v.readnum = 3'd3; v.writenum = 3'd3; v.loadb = 1'b1; slot(v, 1'b1, "STR.SGETB");
    v = b; v.asel = 1'b1; v.loadc = 1'b1; slot(v, 1'b1, "STR.SMOV");
    v = b; v.mem_cmd = 2'b10; slot(v, 1'b1, "STR.SMEM");

    // Undefined 0x0000: fetch and decode only, then straight back to IF1
    b = base_of(16'h0000, 16'h0000, 2'b00, 2'b00);
    fetch(16'h0000, "NOP");

    // HALT, held for 20 cycles
    b = base_of(16'h0000, 16'h0000, 2'b00, 2'b00);
    fetch(16'hE000, "HALT");
    v = b; v.halted = 1'b1;
    repeat (20) slot(v, 1'b1, "HALT.hold");

    // Reset out of HALT
    reset_n = 1'b0;
    slot(rst_v, 1'b1, "RESET.halt");
    reset_n = 1'b1;
    slot(rst_v, 1'b1, "RST.release2");

    // ADD interrupted by reset in its ALU state: no WB write follows
    b = base_of(16'h0008, 16'h0048, 2'b01, 2'b00);
    fetch(16'hA148, "ADDR");
    v = b; v.readnum = 3'd1; v.writenum = 3'd1; v.loada = 1'b1; slot(v, 1'b1, "ADDR.GETA");
    v = b; v.loadb = 1'b1; slot(v, 1'b1, "ADDR.GETB");
    reset_n = 1'b0;
    slot(rst_v, 1'b1, "ADDR.async_reset");
    slot(rst_v, 1'b1, "ADDR.reset_hold");
    reset_n = 1'b1;
    slot(rst_v, 1'b1, "ADDR.release");

    // Machine resumes normally after reset
    mov_imm_m1();

    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu_controller.md
# cpu_controller

Instruction-fetch, decode and sequencing FSM for the simple RISC machine. It drives every control input of the datapath and the memory command/address-select lines. It latches each instruction word from memory into an internal instruction register, decodes the register-number, immediate and opcode fields, and steps the datapath through the state sequence for that instruction. It is the initiator on the datapath control interface; the datapath is the responder.

## Interface
Parameters: none.
- clk  input  1  system clock, all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- mdata  input  16  memory read data (instruction or load data)
- readnum, writenum  output  3  register-file read/write index
- write  output  1  register-file write enable
- vsel  output  4  one-hot writeback select: 1000 mdata, 0100 sximm8, 0010 PC, 0001 C
- loada, loadb, loadc, loads  output  1  A/B/C/status register enables
- shift  output  2  shifter op (IR[4:3])
- asel, bsel  output  1  A-zero select, B-immediate (sximm5) select
- ALUop  output  2  IR[12:11]
- sximm5, sximm8  output  16  sign-extended IR[4:0], IR[7:0]
- load_pc, reset_pc  output  1  PC enable; PC clear (with load_pc)
- load_addr, addr_sel  output  1  data-address register enable; 1 = PC drives memory address
- mem_cmd  output  2  00 NONE, 01 READ, 10 WRITE
- halted  output  1  high in HALT state

## Operation
- Internal 16-bit IR, loaded from mdata when load_ir is active (IF2). Fields: opcode IR[15:13], op IR[12:11], Rn IR[10:8], Rd IR[7:5], sh IR[4:3], Rm IR[2:0].
- Register index: nsel (internal) selects Rn/Rd/Rm. readnum and writenum both equal the selected field.
- Outputs are Moore outputs of the state. Any output not listed for a state is 0. vsel defaults to 0001.
- States and the outputs asserted in each:
  - RST: reset_pc, load_pc → IF1.
  - IF1: addr_sel, mem_cmd=READ → IF2.
  - IF2: addr_sel, mem_cmd=READ, load_ir → UPC.
  - UPC: load_pc → DEC.
  - DEC: no outputs. Branches on {opcode, op}:
    - 110/10 (MOV imm) → WIMM.
    - 110/00 (MOV reg), 101/11 (MVN) → GETB.
    - 101/00, 101/01, 101/10 (ADD, CMP, AND) → GETA.
    - 011/00 (LDR), 100/00 (STR) → GETA.
    - 111 (HALT) → HALT.
    - Anything else → IF1 (NOP).
  - WIMM: nsel=Rn, vsel=0100, write → IF1.
  - GETA: nsel=Rn, loada. Next: LDR/STR → ADDR; otherwise → GETB.
  - GETB: nsel=Rm, loadb → ALU.
  - ALU: loadc; asel=1 for MOV reg/MVN. Also loads=1 for CMP. Next: CMP → IF1; otherwise → WB.
  - WB: nsel=Rd, vsel=0001, write → IF1.
  - ADDR: bsel=1, ALUop forced 00, loadc → LADR.
  - LADR: load_addr. Next: LDR → LMEM; STR → SGETB.
  - LMEM: mem_cmd=READ → LWB.
  - LWB: mem_cmd=READ, nsel=Rd, vsel=1000, write → IF1.
  - SGETB: nsel=Rd, loadb → SMOV.
  - SMOV: asel=1, ALUop forced 00, shift=00, loadc → SMEM.
  - SMEM: mem_cmd=WRITE → IF1.
  - HALT: halted=1, mem_cmd=NONE. Self-loop until reset.
- sximm5 and sximm8 are combinational from IR and valid in every state after IF2.

## Timing
- reset_n low: state is RST immediately, asynchronously, including mid-instruction. IR clears to 0. The only outputs asserted are reset_pc=1 and load_pc=1.
- First rising edge with reset_n high: RST → IF1. RST is not re-entered without reset.
- Memory read is synchronous, one cycle: mdata is valid in the cycle after mem_cmd=READ is first driven. READ is therefore held for two states (IF1/IF2, LMEM/LWB).
- Instruction latency in cycles, counted from IF1 through the last state inclusive:
  - MOV imm: 5.
  - MOV reg, MVN, CMP: 7.
  - ADD, AND: 8.
  - LDR: 9.
  - STR: 10.
- Exactly one write pulse per register-writing instruction. No write for CMP, STR, HALT or NOP.
- Undefined encodings consume 4 cycles (IF1 to DEC) and have no side effects besides PC increment.

## Test plan
- Reset: hold reset_n=0 for 3 cycles → reset_pc=1, load_pc=1, write=0, mem_cmd=00. After release, next cycle is IF1: addr_sel=1, mem_cmd=01.
- MOV R0,#-1 (0xD0FF) → in cycle 5: write=1, writenum=0, vsel=0100, sximm8=0xFFFF. Then IF1.
- ADD R2,R1,R0,LSL#1 (0xA148):
  - GETA: readnum=1, loada.
  - GETB: readnum=0, loadb, shift=01.
  - ALU: loadc, ALUop=00.
  - WB: writenum=2, write, vsel=0001. Total 8 cycles.
- CMP R1,R0 (0xA900) → loads=1 in ALU. No write in any cycle. Back to IF1 after 7 cycles.
- LDR R3,[R0,#1] (0x6061) → ADDR: bsel=1, sximm5=0x0001. LADR: load_addr. LMEM: mem_cmd=01. LWB: write, writenum=3, vsel=1000. STR R3,[R0,#2] (0x8062) → SGETB readnum=3, SMOV asel=1, SMEM mem_cmd=10.
- HALT (0xE000) → halted=1 held for 20 cycles. Undefined 0x0000 returns to IF1 with no write. Asserting reset_n=0 during the ALU state of an ADD → RST immediately, and no WB write occurs.
